// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD-to-VGA scan-out path.
//   - Game screen geometry (GB_W x GB_H)
//   - 640x480@60 VGA timing defaults and window placement defaults
//   - shade_t / rgb12_t typedefs, gray-level lookup, pipeline beam record
package lcd_pkg;

    localparam int GB_W = 160;
    localparam int GB_H = 144;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int DEF_SCALE      = 3;
    localparam int DEF_X_OFF      = 80;
    localparam int DEF_Y_OFF      = 24;
    localparam int DEF_FB_LATENCY = 2;

    typedef logic [1:0]  shade_t;
    typedef logic [11:0] rgb12_t;

    // Index 0 (lightest) is the rightmost element: level 0 -> F ... level 3 -> 0.
    localparam logic [3:0][3:0] GRAY_LEVEL = {4'h0, 4'h5, 4'hA, 4'hF};

    // Per-pixel control bits carried down the delay line next to the BRAM read.
    typedef struct packed {
        logic win;
        logic active;
        logic hs;
        logic vs;
        logic vblank;
        logic fs;
    } beam_t;

    localparam beam_t BEAM_IDLE = '{win: 1'b0, active: 1'b0, hs: 1'b1, vs: 1'b1,
                                    vblank: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters for one VGA mode.
// Ports:
//   clk     in   pixel clock
//   rst_n   in   synchronous reset, active low (raster restarts at 0,0)
//   hcount  out  horizontal position 0..H_TOTAL-1
//   vcount  out  line number 0..V_TOTAL-1, advances when hcount wraps
//   hs_raw  out  hsync for the current position, active low, undelayed
//   vs_raw  out  vsync for the current line, active low, undelayed
//   active  out  current position is inside the visible area
module vga_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       active
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    assign hs_raw = !((hcount >= HS_START) && (hcount < HS_END));
    assign vs_raw = !((vcount >= VS_START) && (vcount < VS_END));
    assign active = (hcount < H_VIS) && (vcount < V_VIS);

endmodule

// File: rtl/lcd_scanout.sv
// lcd_scanout: reads the 160x144 screen buffer and shows it 3x scaled,
// centred in a 640x480 VGA raster.
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous reset, active low
//   fb_addr      out  screen-buffer read address (row*160+col), 0 outside window
//   fb_rd        out  read enable, high while fb_addr is valid (window only)
//   fb_data      in   shade returned FB_LATENCY cycles after fb_addr
//   palette      in   BGP-style shade map, latched at the start of each frame
//   vga_r/g/b    out  4-bit colour channels
//   vga_hs/vs    out  syncs, active low
//   vblank       out  raster line >= V_ACTIVE, aligned with RGB
//   frame_start  out  one-cycle pulse with output pixel (0,0)
// All outputs trail the raster counters by FB_LATENCY+1 cycles.
module lcd_scanout
    import lcd_pkg::*;
#(
    parameter int     H_ACTIVE   = VGA_H_ACTIVE,
    parameter int     H_FP       = VGA_H_FP,
    parameter int     H_SYNC     = VGA_H_SYNC,
    parameter int     H_BP       = VGA_H_BP,
    parameter int     V_ACTIVE   = VGA_V_ACTIVE,
    parameter int     V_FP       = VGA_V_FP,
    parameter int     V_SYNC     = VGA_V_SYNC,
    parameter int     V_BP       = VGA_V_BP,
    parameter int     SCALE      = DEF_SCALE,
    parameter int     X_OFF      = DEF_X_OFF,
    parameter int     Y_OFF      = DEF_Y_OFF,
    parameter int     FB_LATENCY = DEF_FB_LATENCY,
    parameter rgb12_t BORDER_RGB = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] fb_addr,
    output logic        fb_rd,
    input  logic [1:0]  fb_data,
    input  logic [7:0]  palette,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] X_FIRST = 10'(X_OFF);
    localparam logic [9:0] X_PRE   = 10'(X_OFF - 1);
    localparam logic [9:0] X_END   = 10'(X_OFF + GB_W * SCALE);
    localparam logic [9:0] Y_FIRST = 10'(Y_OFF);
    localparam logic [9:0] Y_PRE   = 10'(Y_OFF - 1);
    localparam logic [9:0] Y_END   = 10'(Y_OFF + GB_H * SCALE);
    localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
    localparam logic [1:0] SUB_LAST = 2'(SCALE - 1);

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hs_raw;
    logic       vs_raw;
    logic       active;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .hcount (hcount),
        .vcount (vcount),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw),
        .active (active)
    );

    logic win_x;
    logic win_y;
    logic win;

    assign win_x = (hcount >= X_FIRST) && (hcount < X_END);
    assign win_y = (vcount >= Y_FIRST) && (vcount < Y_END);
    assign win   = win_x && win_y;

    // Source col/row tracking without a divider: sub-counters xs/ys count the
    // SCALE repeats, and are preloaded on the position just before the window
    // so they already hold the right values when the window opens.
    logic [1:0]  xs;
    logic [1:0]  ys;
    logic [7:0]  col;
    logic [14:0] row_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs       <= '0;
            col      <= '0;
            ys       <= '0;
            row_base <= '0;
        end else begin
            if (hcount == X_PRE) begin
                xs  <= '0;
                col <= '0;
            end else if (win_x) begin
                if (xs == SUB_LAST) begin
                    xs  <= '0;
                    col <= col + 8'd1;
                end else begin
                    xs <= xs + 2'd1;
                end
            end

            if (hcount == H_LAST) begin
                if (vcount == Y_PRE) begin
                    ys       <= '0;
                    row_base <= '0;
                end else if (win_y) begin
                    if (ys == SUB_LAST) begin
                        ys       <= '0;
                        row_base <= row_base + 15'(GB_W);
                    end else begin
                        ys <= ys + 2'd1;
                    end
                end
            end
        end
    end

    assign fb_rd   = win;
    assign fb_addr = win ? (row_base + {7'd0, col}) : '0;

    // Palette is sampled only at raster (0,0) so a frame never mixes two maps.
    logic [7:0] pal_q;

    always_ff @(posedge clk) begin
        if ((hcount == '0) && (vcount == '0)) begin
            pal_q <= palette;
        end
    end

    beam_t cur;

    always_comb begin
        cur        = BEAM_IDLE;
        cur.win    = win;
        cur.active = active;
        cur.hs     = hs_raw;
        cur.vs     = vs_raw;
        cur.vblank = (vcount >= V_VIS);
        cur.fs     = (hcount == '0) && (vcount == '0);
    end

    // Control bits wait here while the BRAM read is in flight.
    beam_t dly [FB_LATENCY];
    beam_t tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FB_LATENCY; i++) begin
                dly[i] <= BEAM_IDLE;
            end
        end else begin
            dly[0] <= cur;
            for (int i = 1; i < FB_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tail = dly[FB_LATENCY-1];

    shade_t lvl_sel;
    logic [3:0] lvl;
    rgb12_t rgb_next;

    always_comb begin
        lvl_sel = pal_q[{fb_data, 1'b0} +: 2];
        lvl     = GRAY_LEVEL[lvl_sel];
    end

    // fb_data only steers the colour when the delayed window flag is set, so
    // undriven read data outside the window never reaches the pins.
    always_comb begin
        rgb_next = 12'h000;
        if (tail.win) begin
            rgb_next = {lvl, lvl, lvl};
        end else if (tail.active) begin
            rgb_next = BORDER_RGB;
        end
    end

    rgb12_t rgb_q;
    logic   hs_q;
    logic   vs_q;
    logic   vblank_q;
    logic   fs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            rgb_q    <= rgb_next;
            hs_q     <= tail.hs;
            vs_q     <= tail.vs;
            vblank_q <= tail.vblank;
            fs_q     <= tail.fs;
        end
    end

    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_scanout.sv
module tb_lcd_scanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] fb_addr;
    logic        fb_rd;
    logic [1:0]  fb_data = 2'b00;
    logic [7:0]  palette;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vblank;
    logic        frame_start;

    lcd_scanout dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_data     (fb_data),
        .palette     (palette),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Screen-buffer model: content is addr%4, read latency of two cycles.
    logic [1:0] req;
    logic [1:0] pipe1;

    always @(negedge clk) req <= fb_rd ? fb_addr[1:0] : 2'bxx;

    always @(posedge clk) begin
        pipe1   <= req;
        fb_data <= pipe1;
    end

    // Reference raster position: what the DUT counters should hold.
    int bh = 0;
    int bv = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            bh <= 0;
            bv <= 0;
        end else if (bh == 799) begin
            bh <= 0;
            bv <= (bv == 524) ? 0 : bv + 1;
        end else begin
            bh <= bh + 1;
        end
    end

    int checks = 0;
    int passed = 0;

    int cyc = 0;
    int hs_low = 0;
    int hs_fall = 0;
    int vs_low = 0;
    int fs_cnt = 0;
    int fs_cyc = 0;
    int fs_prev_cyc = 0;
    logic hs_prev = 1'b1;

    wire [11:0] rgb = {vga_r, vga_g, vga_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!vga_hs) begin
            hs_low++;
            if (hs_prev) hs_fall++;
        end
        hs_prev = vga_hs;
        if (!vga_vs) vs_low++;
        if (frame_start) begin
            fs_cnt++;
            fs_prev_cyc = fs_cyc;
            fs_cyc = cyc;
        end
    endtask

    task automatic wait_beam(input int h, input int v);
        int n = 0;
        while (!(bh == h && bv == v) && n < 500000) begin
            tick();
            n++;
        end
        if (!(bh == h && bv == v)) chk("beam_timeout", bh * 1000 + bv, h * 1000 + v);
    endtask

    initial begin
        rst_n   = 1'b0;
        palette = 8'hE4;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_fb_rd", fb_rd, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_vblank", vblank, 0);
        chk("rst_fs", frame_start, 0);

        rst_n = 1'b1;
        cyc = 0; hs_low = 0; hs_fall = 0; vs_low = 0; fs_cnt = 0; hs_prev = 1'b1;
        tick();
        chk("fs_c1", frame_start, 0);
        chk("hs_c1", vga_hs, 1);
        tick();
        chk("fs_c2", frame_start, 0);
        tick();
        chk("fs_first", frame_start, 1);
        tick();
        chk("fs_c4", frame_start, 0);

        wait_beam(80, 23);  chk("rd_80_23", fb_rd, 0);
        wait_beam(79, 24);  chk("rd_79_24", fb_rd, 0);
        wait_beam(80, 24);  chk("rd_80_24", fb_rd, 1);
                            chk("addr_80_24", fb_addr, 0);
        wait_beam(82, 24);  chk("addr_82_24", fb_addr, 0);
                            chk("rgb_79_24", rgb, 12'h000);
        wait_beam(83, 24);  chk("addr_83_24", fb_addr, 1);
                            chk("rgb_80_24", rgb, 12'hFFF);
        wait_beam(86, 24);  chk("rgb_83_24", rgb, 12'hAAA);
        wait_beam(89, 24);  chk("rgb_86_24", rgb, 12'h555);
        wait_beam(559, 24); chk("rd_559_24", fb_rd, 1);
                            chk("addr_559_24", fb_addr, 159);
        wait_beam(560, 24); chk("rd_560_24", fb_rd, 0);
                            chk("addr_560_24", fb_addr, 0);
        wait_beam(80, 27);  chk("addr_80_27", fb_addr, 160);

        wait_beam(658, 30); chk("hs_655", vga_hs, 1);
        wait_beam(659, 30); chk("hs_656", vga_hs, 0);
        wait_beam(754, 30); chk("hs_751", vga_hs, 0);
        wait_beam(755, 30); chk("hs_752", vga_hs, 1);

        wait_beam(13, 100);  chk("rgb_border_10_100", rgb, 12'h000);
                             chk("vblank_10_100", vblank, 0);
        wait_beam(86, 100);  chk("rgb_83_100", rgb, 12'hAAA);
        wait_beam(703, 100); chk("rgb_blank_700_100", rgb, 12'h000);

        wait_beam(0, 200);
        palette = 8'h1B;
        wait_beam(83, 210);  chk("rgb_80_210_oldpal", rgb, 12'hFFF);
        wait_beam(559, 455); chk("rd_559_455", fb_rd, 1);
                             chk("addr_559_455", fb_addr, 23039);
        wait_beam(80, 456);  chk("rd_80_456", fb_rd, 0);

        wait_beam(2, 480); chk("vblank_799_479", vblank, 0);
        wait_beam(3, 480); chk("vblank_0_480", vblank, 1);
        wait_beam(2, 490); chk("vs_489", vga_vs, 1);
        wait_beam(3, 490); chk("vs_490", vga_vs, 0);
        wait_beam(2, 492); chk("vs_491", vga_vs, 0);
        wait_beam(3, 492); chk("vs_492", vga_vs, 1);

        wait_beam(3, 0);
        chk("fs_frame2", frame_start, 1);
        chk("fs_period", fs_cyc - fs_prev_cyc, 420000);
        chk("fs_count", fs_cnt, 2);
        chk("hs_low_cycles", hs_low, 50400);
        chk("line_count", hs_fall, 525);
        chk("vs_low_cycles", vs_low, 1600);
        chk("vblank_0_0", vblank, 0);

        wait_beam(83, 24); chk("rgb_80_24_newpal", rgb, 12'h000);
        wait_beam(86, 24); chk("rgb_83_24_newpal", rgb, 12'h555);

        wait_beam(100, 300);
        chk("rgb_97_300", rgb, 12'h555);
        chk("rd_100_300", fb_rd, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_rgb", rgb, 12'h000);
        chk("mid_rst_hs", vga_hs, 1);
        chk("mid_rst_vs", vga_vs, 1);
        chk("mid_rst_rd", fb_rd, 0);
        chk("mid_rst_addr", fb_addr, 0);
        tick();
        chk("mid_rst_fs1", frame_start, 0);
        chk("mid_rst_rgb1", rgb, 12'h000);
        tick();
        chk("mid_rst_fs2", frame_start, 0);
        tick();
        chk("mid_rst_fs3", frame_start, 1);
        wait_beam(83, 24); chk("post_rst_addr_83_24", fb_addr, 1);
        wait_beam(86, 24); chk("post_rst_rgb_83_24", rgb, 12'h555);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Reader at the far end of the PPU's LCD screen buffer: the PPU writes 2-bit shades through lcd_addr/lcd_write/pixel_out, and this block reads them back out.
- Scans the 160x144 buffer, scales it 3x into a 480x432 window centred in a 640x480@60 VGA raster, and drives 12-bit RGB plus syncs.
- Runs in the 25.175 MHz pixel-clock domain on the read port of the dual-port screen-buffer BRAM.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SCALE, 3, integer upscale factor
- X_OFF, 80, first window column
- Y_OFF, 24, first window line
- FB_LATENCY, 2, BRAM read latency in cycles
- BORDER_RGB, 12'h000, colour outside the window

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active low
- fb_addr  out  15  screen-buffer read address (row*160+col)
- fb_rd  out  1  read enable, high while fb_addr is valid
- fb_data  in  2  shade returned FB_LATENCY cycles after fb_addr
- palette  in  8  BGP-style map; shade i uses palette[2i+1:2i]
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vblank  out  1  high while raster line >= V_ACTIVE, aligned with RGB
- frame_start  out  1  one-cycle pulse with the first output pixel (0,0) of each frame

Behaviour:
- Counters: hcount 0..H_TOTAL-1 (800). vcount 0..V_TOTAL-1 (525) advances when hcount wraps; vcount wraps to 0 after 524.
- Window: X_OFF <= hcount < X_OFF+160*SCALE (80..559) and Y_OFF <= vcount < Y_OFF+144*SCALE (24..455).
- Address generation, divider-free:
  - sub-counters xs/ys 0..SCALE-1 and source col/row;
  - row_base register += 160 when ys wraps, cleared at window top;
  - fb_addr = row_base + col.
- fb_rd=1 only inside the window; otherwise fb_addr=0, fb_rd=0.
- Pipeline: RGB, hs, vs, vblank and frame_start for beam (h,v) appear registered L = FB_LATENCY+1 = 3 cycles after the counters hold (h,v). The delay line is shared so all outputs stay mutually aligned.
- hsync asserted (0) for hcount 656..751; vsync asserted for vcount 490..491; both before the L delay.
- Colour (registered):
  - active and in window: g = palette[2s+1:2s] of fb_data s; level 0->F, 1->A, 2->5, 3->0 on all three channels;
  - active, outside window: BORDER_RGB;
  - blanking: 12'h000.
- Palette is latched once per frame at hcount=0,vcount=0 (before the delay). Mid-frame palette changes take effect only on the next frame; no tearing.
- Reset (rst_n=0 on a clk edge) clears counters, sub-counters, row_base and the delay line. Until the pipeline refills, outputs are RGB=0, hs=vs=1, vblank=0, frame_start=0, fb_rd=0, fb_addr=0. Reset mid-frame restarts the raster at (0,0); the first frame_start occurs L cycles after release.
- fb_data is ignored whenever the delayed window flag is 0. X/Z on fb_data outside the window must not reach outputs.
- No backpressure; the block never stalls.

Decomposition:
- Package lcd_pkg:
  - GB_W=160, GB_H=144;
  - the VGA timing defaults;
  - shade_t (2-bit) and rgb12_t typedefs;
  - gray-level constant array {F,A,5,0}.
- Sub-module vga_timing_gen: hcount/vcount, raw hs/vs, active flag. lcd_scanout adds window/address logic, palette and the delay line.

Test Plan:
- Reset held 5 cycles, released -> vga_hs=vga_vs=1, RGB=0, fb_rd=0; first frame_start exactly 3 cycles after release.
- Free-run one frame -> hs low for 96 cycles per 800-cycle line; vs low for lines 490..491; exactly 525 lines per frame; frame_start period 420000 cycles.
- Address sweep, checked at the counter stage:
  - (80,24) -> fb_addr 0
  - (82,24) -> 0
  - (83,24) -> 1
  - (80,27) -> 160
  - (559,455) -> 23039
  - (79,24) and (560,24) -> fb_rd=0
- Model BRAM (latency 2) filled with addr%4, palette=8'hE4 -> pixel (80,24) outputs 12'hFFF, (83,24) outputs 12'hAAA; border pixel (10,100) outputs BORDER_RGB; blanking (700,100) outputs 12'h000.
- Change palette to 8'h1B mid-frame (vcount 200) -> rest of frame unchanged; next frame's shade 0 outputs 12'h000.
- Assert rst_n=0 for 1 cycle at vcount 300 -> counters restart at (0,0), outputs blank/deasserted for 3 cycles, then a normal frame follows.
